// File: rtl/dmem_pipe_if.sv
// rtl/dmem_pipe_if.sv - request/response bundle between the load/store unit and dmem_pipe
interface dmem_pipe_if #(
    parameter int N = 16,
    parameter int R = 8
);
    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [R-1:0]     addr;
    logic [N-1:0]     writedata;
    logic [N/8-1:0]   byte_en;
    logic             rsp_valid;
    logic [N-1:0]     readdata;
    logic             busy;
    logic             err;

    modport master (
        output req_valid, req_write, addr, writedata, byte_en,
        input  req_ready, rsp_valid, readdata, busy, err
    );

    modport slave (
        input  req_valid, req_write, addr, writedata, byte_en,
        output req_ready, rsp_valid, readdata, busy, err
    );
endinterface

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - byte-enabled data memory with registered reads and range checking
// Optional post-reset zeroing sequencer enabled by macro DMEM_CLEAR_EN.
module dmem_pipe #(
    parameter int N     = 16,
    parameter int R     = 8,
    parameter int DEPTH = 2**R
) (
    input  logic       clk,
    input  logic       rst_n,
    dmem_pipe_if.slave bus
);
    localparam int           NB      = N / 8;
    localparam logic [R:0]   DEPTH_W = (R+1)'(DEPTH);

    logic [N-1:0] mem [DEPTH];

    logic         ready;
    logic         busy_o;
    logic         clr_we;
    logic [R-1:0] clr_addr;
    logic         accept;
    logic         in_range;

`ifdef DMEM_CLEAR_EN
    typedef enum logic {S_CLEAR, S_READY} state_t;

    localparam logic [R-1:0] CNT_LAST = R'(DEPTH - 1);

    state_t       state, state_next;
    logic [R-1:0] cnt, cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_we     = 1'b0;
        ready      = 1'b0;
        busy_o     = 1'b0;
        case (state)
            S_CLEAR: begin
                busy_o = 1'b1;
                clr_we = 1'b1;
                if (cnt == CNT_LAST) state_next = S_READY;
                else                 cnt_next   = cnt + R'(1);
            end
            S_READY: ready = 1'b1;
            default: state_next = S_CLEAR;
        endcase
    end

    assign clr_addr = cnt;
`else
    logic rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    assign ready    = rdy_q;
    assign busy_o   = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    assign accept   = bus.req_valid && ready;
    // Compare one bit wider so DEPTH == 2**R never aliases through truncation.
    assign in_range = ({1'b0, bus.addr} < DEPTH_W);

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (accept && bus.req_write && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (bus.byte_en[i]) mem[bus.addr][8*i +: 8] <= bus.writedata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.readdata  <= '0;
            bus.err       <= 1'b0;
        end else begin
            bus.rsp_valid <= accept && !bus.req_write;
            bus.err       <= accept && !in_range;
            if (accept && !bus.req_write) bus.readdata <= in_range ? mem[bus.addr] : '0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.busy      = busy_o;
endmodule

// File: tb/tb_dmem_pipe.sv
// tb/tb_dmem_pipe.sv - directed self-checking bench for dmem_pipe (N=16, R=8, DEPTH=200)
module tb_dmem_pipe;
`ifdef DMEM_CLEAR_EN
    localparam int CLR_EDGES = 200;
    localparam int BUSY_RST  = 1;
`else
    localparam int CLR_EDGES = 1;
    localparam int BUSY_RST  = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   edges;
    int   busy_bad;

    dmem_pipe_if #(.N(16), .R(8)) bus ();

    dmem_pipe #(.N(16), .R(8), .DEPTH(200)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive at a falling edge, accepted at the next rising edge, return at the following falling edge.
    task automatic issue(input logic w, input logic [7:0] a, input logic [15:0] d, input logic [1:0] be);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.addr      = a;
        bus.writedata = d;
        bus.byte_en   = be;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (bus.req_ready !== 1'b1 && n < 1000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.req_ready !== 1'b1 && bus.busy !== BUSY_RST[0]) bad++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_busy"},  32'(bus.busy),      32'(BUSY_RST));
        check({tag, "_rspv"},  32'(bus.rsp_valid), 32'd0);
        check({tag, "_rdata"}, 32'(bus.readdata),  32'd0);
        check({tag, "_err"},   32'(bus.err),       32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.addr      = '0;
        bus.writedata = '0;
        bus.byte_en   = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        wait_ready(edges, busy_bad);
        check("clear_edges", 32'(edges), 32'(CLR_EDGES));
        check("clear_busy", 32'(busy_bad), 32'd0);
        check("ready_busy", 32'(bus.busy), 32'd0);

`ifndef DMEM_CLEAR_EN
        issue(1'b1, 8'h05, 16'h0000, 2'b11);
        issue(1'b1, 8'hC7, 16'h0000, 2'b11);
`endif
        issue(1'b0, 8'h05, 16'h0, 2'b00);
        check("rd05_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd05_data",  32'(bus.readdata),  32'h0000);
        idle();
        check("rd05_drop",  32'(bus.rsp_valid), 32'd0);

        issue(1'b1, 8'h00, 16'hFFFF, 2'b11);
        check("wr00_novalid", 32'(bus.rsp_valid), 32'd0);
        issue(1'b0, 8'h00, 16'h0, 2'b00);
        check("rd00_valid", 32'(bus.rsp_valid), 32'd1);
        check("rd00_data",  32'(bus.readdata),  32'hFFFF);
        check("rd00_err",   32'(bus.err),       32'd0);

        issue(1'b1, 8'h01, 16'h00FF, 2'b11);
        issue(1'b1, 8'h01, 16'hAB00, 2'b10);
        issue(1'b1, 8'h01, 16'h1111, 2'b00);
        issue(1'b0, 8'h01, 16'h0, 2'b00);
        check("lanes_data", 32'(bus.readdata), 32'hABFF);

        issue(1'b1, 8'h02, 16'h1234, 2'b11);
        issue(1'b0, 8'h02, 16'h0, 2'b00);
        check("raw_data", 32'(bus.readdata), 32'h1234);

        issue(1'b0, 8'h00, 16'h0, 2'b00);
        check("b2b0_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b0_data",  32'(bus.readdata),  32'hFFFF);
        issue(1'b0, 8'h01, 16'h0, 2'b00);
        check("b2b1_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b1_data",  32'(bus.readdata),  32'hABFF);
        issue(1'b0, 8'h02, 16'h0, 2'b00);
        check("b2b2_valid", 32'(bus.rsp_valid), 32'd1);
        check("b2b2_data",  32'(bus.readdata),  32'h1234);
        idle();
        check("b2b_drop", 32'(bus.rsp_valid), 32'd0);
        check("hold_data", 32'(bus.readdata), 32'h1234);

        issue(1'b1, 8'hC8, 16'hBEEF, 2'b11);
        check("oorw_err",   32'(bus.err),       32'd1);
        check("oorw_valid", 32'(bus.rsp_valid), 32'd0);
        idle();
        check("oorw_errdrop", 32'(bus.err), 32'd0);
        issue(1'b0, 8'hC8, 16'h0, 2'b00);
        check("oorr_valid", 32'(bus.rsp_valid), 32'd1);
        check("oorr_data",  32'(bus.readdata),  32'h0000);
        check("oorr_err",   32'(bus.err),       32'd1);
        issue(1'b0, 8'hC7, 16'h0, 2'b00);
        check("lastw_data", 32'(bus.readdata), 32'h0000);
        check("lastw_err",  32'(bus.err),      32'd0);

        issue(1'b0, 8'h00, 16'h0, 2'b00);
        check("pre_rst_data", 32'(bus.readdata), 32'hFFFF);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rsp_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

`ifdef DMEM_CLEAR_EN
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_clr_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`endif
        wait_ready(edges, busy_bad);
        check("reclear_edges", 32'(edges), 32'(CLR_EDGES));
        check("reclear_busy",  32'(busy_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
